// File: rtl/sd_pkg.sv
// Shared types and frame geometry for the SD CMD-line response receiver.
package sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_RECV,
    ST_CHECK
  } sd_state_e;

  localparam int SHORT_LEN = 48;   // R1/R3/R6/R7 frame bits
  localparam int LONG_LEN  = 136;  // R2 frame bits
  localparam int HDR_W     = 8;    // start + transmission + 6-bit index/reserved
  localparam int ARG_W     = 32;
  localparam int DATA_W    = 120;
  localparam int CRC_W     = 7;

  localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;  // x^7 + x^3 + 1

endpackage

// File: rtl/sd_resp_crc7.sv
// Serial CRC7 (x^7+x^3+1), zero init, one bit per enabled clock; result visible
// the cycle after the last enabled bit. Independent of the command-path generator.
module sd_resp_crc7
  import sd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q;
  logic             fb;

  assign fb    = bit_i ^ crc_q[CRC_W-1];
  assign crc_o = crc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
    end
  end

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver: 48-bit responses, plus 136-bit R2 when SD_RESP_R2_EN
// is defined. DONE pulses one cycle after the end bit; START is ignored while BUSY.
module sd_cmd_resp_rx
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         LONG,
  input  logic         NO_CRC,
  input  logic         CMD_IN,
  output logic         BUSY,
  output logic         DONE,
  output logic [5:0]   RESP_IDX,
  output logic [119:0] RESP,
  output logic         CRC_ERR,
  output logic         END_ERR,
  output logic         TX_ERR,
  output logic         TIMEOUT_ERR
);

`ifdef SD_RESP_R2_EN
  localparam int BCW = 8;
  localparam int DW  = DATA_W;
`else
  localparam int BCW = 6;
  localparam int DW  = ARG_W;
`endif
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  sd_state_e        state_q, state_d;
  logic [TCW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             long_q, long_d;
  logic             no_crc_q, no_crc_d;
  logic [5:0]       idx_q, idx_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CRC_W-1:0] crc_rx_q, crc_rx_d;
  logic [5:0]       resp_idx_q, resp_idx_d;
  logic [DW-1:0]    resp_q, resp_d;
  logic             crc_err_q, crc_err_d;
  logic             end_err_q, end_err_d;
  logic             tx_err_q, tx_err_d;
  logic             tmo_err_q, tmo_err_d;

  logic             crc_clr, crc_en;
  logic [CRC_W-1:0] crc_val;
  logic             start_ok;
  logic [BCW-1:0]   data_lo, data_hi, last_pos;

`ifndef SD_RESP_R2_EN
  logic unused_long;
  assign unused_long = LONG;
`endif

  sd_resp_crc7 u_crc (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .bit_i (CMD_IN),
    .crc_o (crc_val)
  );

  // Bit positions count from 0 at the transmission bit (the bit after start).
  always_comb begin
    data_lo = BCW'(HDR_W - 1);
`ifdef SD_RESP_R2_EN
    data_hi  = long_q ? BCW'(HDR_W + DATA_W - 2) : BCW'(HDR_W + ARG_W - 2);
    last_pos = long_q ? BCW'(LONG_LEN - 2) : BCW'(SHORT_LEN - 2);
`else
    data_hi  = BCW'(HDR_W + ARG_W - 2);
    last_pos = BCW'(SHORT_LEN - 2);
`endif
  end

  assign start_ok = START && ((state_q == ST_IDLE) || (state_q == ST_CHECK));

  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    long_d     = long_q;
    no_crc_d   = no_crc_q;
    idx_d      = idx_q;
    data_d     = data_q;
    crc_rx_d   = crc_rx_q;
    resp_idx_d = resp_idx_q;
    resp_d     = resp_q;
    crc_err_d  = crc_err_q;
    end_err_d  = end_err_q;
    tx_err_d   = tx_err_q;
    tmo_err_d  = tmo_err_q;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;

    case (state_q)
      ST_WAIT_START: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (!CMD_IN) begin
          // Short-frame CRC includes the start bit; long-frame CRC starts at data.
          crc_en    = !long_q;
          bit_cnt_d = '0;
          state_d   = ST_RECV;
        end else if (tmo_cnt_d == TCW'(TIMEOUT_CYC)) begin
          tmo_err_d = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_RECV: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        crc_en    = (bit_cnt_q <= data_hi) && (!long_q || (bit_cnt_q >= data_lo));
        if (bit_cnt_q == '0) begin
          tx_err_d = CMD_IN;
        end
        if ((bit_cnt_q >= BCW'(1)) && (bit_cnt_q < data_lo)) begin
          idx_d = {idx_q[4:0], CMD_IN};
        end
        if ((bit_cnt_q >= data_lo) && (bit_cnt_q <= data_hi)) begin
          data_d = {data_q[DW-2:0], CMD_IN};
        end
        if ((bit_cnt_q > data_hi) && (bit_cnt_q < last_pos)) begin
          crc_rx_d = {crc_rx_q[CRC_W-2:0], CMD_IN};
        end
        if (bit_cnt_q == last_pos) begin
          end_err_d  = !CMD_IN;
          crc_err_d  = !no_crc_q && (crc_rx_q != crc_val);
          resp_idx_d = idx_q;
          resp_d     = data_q;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (start_ok) begin
      state_d   = ST_WAIT_START;
      tmo_cnt_d = '0;
      bit_cnt_d = '0;
`ifdef SD_RESP_R2_EN
      long_d    = LONG;
`else
      long_d    = 1'b0;
`endif
      no_crc_d  = NO_CRC;
      idx_d     = '0;
      data_d    = '0;
      crc_rx_d  = '0;
      crc_err_d = 1'b0;
      end_err_d = 1'b0;
      tx_err_d  = 1'b0;
      tmo_err_d = 1'b0;
      crc_clr   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      tmo_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      long_q     <= 1'b0;
      no_crc_q   <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      crc_rx_q   <= '0;
      resp_idx_q <= '0;
      resp_q     <= '0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      long_q     <= long_d;
      no_crc_q   <= no_crc_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      crc_rx_q   <= crc_rx_d;
      resp_idx_q <= resp_idx_d;
      resp_q     <= resp_d;
      crc_err_q  <= crc_err_d;
      end_err_q  <= end_err_d;
      tx_err_q   <= tx_err_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign BUSY        = (state_q == ST_WAIT_START) || (state_q == ST_RECV);
  assign DONE        = (state_q == ST_CHECK);
  assign RESP_IDX    = resp_idx_q;
  assign RESP        = 120'(resp_q);
  assign CRC_ERR     = crc_err_q;
  assign END_ERR     = end_err_q;
  assign TX_ERR      = tx_err_q;
  assign TIMEOUT_ERR = tmo_err_q;

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Scoreboard bench for sd_cmd_resp_rx: directed 48-bit frames, timeout and reset abort.
module tb_sd_cmd_resp_rx;

  localparam int TIMEOUT_CYC = 64;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic         LONG = 1'b0;
  logic         NO_CRC = 1'b0;
  logic         CMD_IN = 1'b1;
  logic         BUSY, DONE;
  logic [5:0]   RESP_IDX;
  logic [119:0] RESP;
  logic         CRC_ERR, END_ERR, TX_ERR, TIMEOUT_ERR;

  sd_cmd_resp_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .LONG        (LONG),
    .NO_CRC      (NO_CRC),
    .CMD_IN      (CMD_IN),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .RESP_IDX    (RESP_IDX),
    .RESP        (RESP),
    .CRC_ERR     (CRC_ERR),
    .END_ERR     (END_ERR),
    .TX_ERR      (TX_ERR),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]   idx;
    logic [119:0] resp;
    logic         crc, endb, tx, tmo;
  } exp_t;

  typedef struct {
    logic [47:0] frame;
    logic        nc;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        crc, endb, tx;
    int          poke;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input logic [119:0] act, input logic [119:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every DONE pulse is matched against the oldest expected response.
  always @(negedge CLK) begin
    if (!RST && DONE === 1'b1) begin
      exp_t e;
      done_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 120'(1), 120'(0));
      end else begin
        e = exp_q.pop_front();
        chk("resp_idx", 120'(RESP_IDX), 120'(e.idx));
        chk("resp", RESP, e.resp);
        chk("crc_err", 120'(CRC_ERR), 120'(e.crc));
        chk("end_err", 120'(END_ERR), 120'(e.endb));
        chk("tx_err", 120'(TX_ERR), 120'(e.tx));
        chk("timeout_err", 120'(TIMEOUT_ERR), 120'(e.tmo));
        chk("busy_at_done", 120'(BUSY), 120'(0));
      end
    end
  end

  // Called at a negedge; returns at the negedge where DONE should be high.
  task automatic send_frame(input logic [47:0] f, input logic nc, input exp_t e, input int poke);
    exp_q.push_back(e);
    START  = 1'b1;
    LONG   = 1'b0;
    NO_CRC = nc;
    @(negedge CLK);
    START  = 1'b0;
    NO_CRC = 1'b0;
    chk("busy_after_start", 120'(BUSY), 120'(1));
    chk("flags_clr_on_start", 120'({CRC_ERR, END_ERR, TX_ERR, TIMEOUT_ERR}), 120'(0));
    repeat (2) @(negedge CLK);
    for (int i = 47; i >= 0; i--) begin
      CMD_IN = f[i];
      START  = ((47 - i) == poke);
      @(negedge CLK);
    end
    START  = 1'b0;
    CMD_IN = 1'b1;
    chk("done_latency", 120'(DONE), 120'(1));
  endtask

  vec_t vecs[8];
  exp_t e;
  logic [5:0]   last_idx;
  logic [119:0] last_resp;
  int           cyc;
  int           d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{48'h000000000001, 1'b0, 6'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, -1};
    vecs[1] = '{48'h400000000095, 1'b0, 6'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 10};
    vecs[2] = '{48'h000000000003, 1'b0, 6'h00, 32'h00000000, 1'b1, 1'b0, 1'b0, -1};
    vecs[3] = '{48'h000000000003, 1'b1, 6'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, -1};
    vecs[4] = '{48'h3F80FF8000FF, 1'b1, 6'h3F, 32'h80FF8000, 1'b0, 1'b0, 1'b0, -1};
    vecs[5] = '{48'h48000001AA87, 1'b0, 6'h08, 32'h000001AA, 1'b0, 1'b0, 1'b1, -1};
    vecs[6] = '{48'h770000000065, 1'b0, 6'h37, 32'h00000000, 1'b0, 1'b0, 1'b1, 25};
    vecs[7] = '{48'h000000000000, 1'b0, 6'h00, 32'h00000000, 1'b0, 1'b1, 1'b0, -1};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", 120'(BUSY), 120'(0));
    chk("rst_done", 120'(DONE), 120'(0));
    chk("rst_resp", RESP, 120'(0));
    chk("rst_idx", 120'(RESP_IDX), 120'(0));
    chk("rst_flags", 120'({CRC_ERR, END_ERR, TX_ERR, TIMEOUT_ERR}), 120'(0));

    // Back-to-back frames: each START lands in the previous DONE cycle.
    foreach (vecs[k]) begin
      e = '{vecs[k].idx, {88'd0, vecs[k].arg}, vecs[k].crc, vecs[k].endb, vecs[k].tx, 1'b0};
      send_frame(vecs[k].frame, vecs[k].nc, e, vecs[k].poke);
      last_idx  = vecs[k].idx;
      last_resp = {88'd0, vecs[k].arg};
    end
    repeat (3) @(negedge CLK);

    // Timeout: line stays idle; RESP and RESP_IDX keep the last frame's values.
    exp_q.push_back('{last_idx, last_resp, 1'b0, 1'b0, 1'b0, 1'b1});
    START = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK);
      START = 1'b0;
      cyc++;
    end while (DONE !== 1'b1 && cyc < 200);
    chk("tmo_latency", 120'(cyc), 120'(TIMEOUT_CYC + 1));
    @(negedge CLK);
    chk("tmo_busy_after", 120'(BUSY), 120'(0));
    repeat (2) @(negedge CLK);

    // Reset at bit 20 of a frame: no DONE, receiver idle and cleared.
    d0 = done_seen;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      CMD_IN = 1'b0;
      @(negedge CLK);
    end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST    = 1'b0;
    CMD_IN = 1'b1;
    chk("abort_busy", 120'(BUSY), 120'(0));
    chk("abort_resp", RESP, 120'(0));
    repeat (10) @(negedge CLK);
    chk("abort_no_done", 120'(done_seen - d0), 120'(0));

    e = '{6'h00, 120'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    send_frame(48'h000000000001, 1'b0, e, -1);
    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", 120'(exp_q.size()), 120'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
